// File: rtl/spi_slave_axi_cmd_seq.sv
// SPI word stream to spi_slave_axi_plug command sequencer (axi_aclk domain).
// Optional: SPI_AXI_SEQ_ERRCNT_EN adds a saturating err_count output.
module spi_slave_axi_cmd_seq #(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [31:0]               cmd_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cs,
  output logic [AXI_ADDR_WIDTH-1:0] plug_addr,
  output logic                      plug_addr_valid,
  output logic                      plug_start_tx,
  output logic [15:0]               plug_wrap_length,
  output logic [31:0]               plug_rx_data,
  output logic                      plug_rx_valid,
  input  logic                      plug_rx_ready,
  input  logic                      plug_tx_valid,
  input  logic                      plug_tx_ready,
  output logic                      busy,
`ifdef SPI_AXI_SEQ_ERRCNT_EN
  output logic [7:0]                err_count,
`endif
  output logic                      err_opcode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_WDATA,
    S_RSTART,
    S_RDATA
  } state_t;

  state_t      state_q, state_d;
  logic        is_rd_q;
  logic [15:0] cnt_q;
  logic        op_wr, op_rd;
  logic        tx_hs;
  logic        cap_hdr, cap_addr;
  logic        cnt_dec, err_d, abort;

  assign plug_rx_data = cmd_data;
  assign busy         = (state_q != S_IDLE);
  assign tx_hs        = plug_tx_valid & plug_tx_ready;

  // Opcode decode of the current word.
  always_comb begin
    op_wr = 1'b0;
    op_rd = 1'b0;
    unique case (1'b1)
      (cmd_data[31:24] == 8'h02): op_wr = 1'b1;
      (cmd_data[31:24] == 8'h0B): op_rd = 1'b1;
      default: ;
    endcase
  end

  // Next state, handshake outputs and capture strobes.
  always_comb begin
    state_d         = state_q;
    cmd_ready       = 1'b0;
    plug_addr_valid = 1'b0;
    plug_start_tx   = 1'b0;
    plug_rx_valid   = 1'b0;
    cap_hdr         = 1'b0;
    cap_addr        = 1'b0;
    cnt_dec         = 1'b0;
    err_d           = 1'b0;
    abort           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = !cs;
        if (cmd_valid && !cs) begin
          if (op_wr || op_rd) begin
            cap_hdr = 1'b1;
            state_d = S_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        cmd_ready = !cs;
        if (cmd_valid && !cs) begin
          cap_addr = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        plug_addr_valid = !cs;
        state_d = is_rd_q ? S_RSTART : S_WDATA;
      end
      S_WDATA: begin
        plug_rx_valid = cmd_valid & !cs;
        cmd_ready     = plug_rx_ready & !cs;
        if (cmd_valid && plug_rx_ready && !cs) begin
          cnt_dec = 1'b1;
          if (cnt_q == 16'd1) state_d = S_IDLE;
        end
      end
      S_RSTART: begin
        plug_start_tx = !cs;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        cmd_ready = !cs;
        if (tx_hs && !cs) begin
          cnt_dec = 1'b1;
          if (cnt_q == 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cs && state_q != S_IDLE) begin
      abort   = 1'b1;
      state_d = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Command context: opcode, burst counter, plug configuration, error pulse.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      is_rd_q          <= 1'b0;
      cnt_q            <= '0;
      plug_addr        <= '0;
      plug_wrap_length <= '0;
      err_opcode       <= 1'b0;
    end else begin
      err_opcode <= err_d;
      if (cap_hdr) begin
        is_rd_q          <= op_rd;
        plug_wrap_length <= cmd_data[15:0];
        cnt_q <= (cmd_data[15:0] == 16'd0) ? 16'd1 : cmd_data[15:0];
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 16'd1;
      end
      if (cap_addr) plug_addr <= cmd_data[AXI_ADDR_WIDTH-1:0];
    end
  end

`ifdef SPI_AXI_SEQ_ERRCNT_EN
  // Saturating count of bad opcodes and chip-select aborts.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) err_count <= '0;
    else if ((err_d || abort) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_slave_axi_cmd_seq.sv
// Directed plus randomized bench for spi_slave_axi_cmd_seq.
// Expected plug traffic is derived per command from header/address/data.
module tb_spi_slave_axi_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cs = 1'b0;
  logic [31:0] plug_addr;
  logic        plug_addr_valid;
  logic        plug_start_tx;
  logic [15:0] plug_wrap_length;
  logic [31:0] plug_rx_data;
  logic        plug_rx_valid;
  logic        plug_rx_ready = 1'b1;
  logic        plug_tx_valid = 1'b0;
  logic        plug_tx_ready = 1'b0;
  logic        busy;
  logic        err_opcode;
`ifdef SPI_AXI_SEQ_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;

  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b1;

  int cyc = 0;
  int rx_n = 0;
  logic [31:0] rx_log [0:1023];
  int addr_pulses = 0;
  int start_pulses = 0;
  int err_pulses = 0;
  int cmd_hs_n = 0;
  int addr_cyc = 0;
  int start_cyc = 0;
  logic [31:0] last_addr = '0;
  logic [15:0] last_wrap = '0;

  spi_slave_axi_cmd_seq #(.AXI_ADDR_WIDTH(32)) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .cmd_data(cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cs(cs),
    .plug_addr(plug_addr),
    .plug_addr_valid(plug_addr_valid),
    .plug_start_tx(plug_start_tx),
    .plug_wrap_length(plug_wrap_length),
    .plug_rx_data(plug_rx_data),
    .plug_rx_valid(plug_rx_valid),
    .plug_rx_ready(plug_rx_ready),
    .plug_tx_valid(plug_tx_valid),
    .plug_tx_ready(plug_tx_ready),
    .busy(busy),
`ifdef SPI_AXI_SEQ_ERRCNT_EN
    .err_count(err_count),
`endif
    .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Plug RX backpressure: fixed or random.
  always @(posedge clk) begin
    #2;
    plug_rx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor of plug-side events, sampled mid-cycle.
  always @(negedge clk) begin
    if (plug_rx_valid && plug_rx_ready) begin
      rx_log[rx_n[9:0]] = plug_rx_data;
      rx_n = rx_n + 1;
    end
    if (plug_addr_valid) begin
      addr_pulses = addr_pulses + 1;
      addr_cyc = cyc;
      last_addr = plug_addr;
      last_wrap = plug_wrap_length;
    end
    if (plug_start_tx) begin
      start_pulses = start_pulses + 1;
      start_cyc = cyc;
    end
    if (err_opcode) err_pulses = err_pulses + 1;
    if (cmd_valid && cmd_ready) cmd_hs_n = cmd_hs_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    bit ok;
    ok = 1'b0;
    cmd_data = w;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_write(input logic [15:0] len, input logic [31:0] addr,
                          input bit rnd);
    int n, rx0, a0, s0;
    logic [31:0] exp_q[$];
    logic [31:0] d;
    n = (len == 16'd0) ? 1 : int'(len);
    rx0 = rx_n;
    a0 = addr_pulses;
    s0 = start_pulses;
    rdy_rand = rnd;
    rdy_force = 1'b1;
    send_word({8'h02, 8'($urandom), len}, "wr_hdr");
    send_word(addr, "wr_addr");
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      send_word(d, "wr_data");
    end
    rdy_rand = 1'b0;
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
    chk("wr_addr_pulses", addr_pulses - a0, 32'd1);
    chk("wr_addr", last_addr, addr);
    chk("wr_wrap", {16'd0, last_wrap}, {16'd0, len});
    chk("wr_no_start", start_pulses - s0, 32'd0);
    chk("wr_rx_count", rx_n - rx0, n);
    for (int i = 0; i < n; i++)
      chk("wr_rx_data", rx_log[10'(rx0 + i)], exp_q[i]);
  endtask

  task automatic do_read(input logic [15:0] len, input logic [31:0] addr);
    int n, rx0, a0, s0, hs0, rd_cycles, gap;
    n = (len == 16'd0) ? 1 : int'(len);
    rx0 = rx_n;
    a0 = addr_pulses;
    s0 = start_pulses;
    hs0 = cmd_hs_n;
    rd_cycles = 0;
    send_word({8'h0B, 8'($urandom), len}, "rd_hdr");
    send_word(addr, "rd_addr");
    cmd_valid = 1'b1;
    cmd_data = $urandom;
    tick();
    tick();
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        plug_tx_valid = 1'($urandom_range(0, 1));
        plug_tx_ready = 1'b0;
        cmd_data = $urandom;
        rd_cycles++;
        tick();
      end
      chk("rd_busy", {31'd0, busy}, 32'd1);
      plug_tx_valid = 1'b1;
      plug_tx_ready = 1'b1;
      cmd_data = $urandom;
      rd_cycles++;
      tick();
      plug_tx_valid = 1'b0;
      plug_tx_ready = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("rd_busy_end", {31'd0, busy}, 32'd0);
    chk("rd_addr_pulses", addr_pulses - a0, 32'd1);
    chk("rd_start_pulses", start_pulses - s0, 32'd1);
    chk("rd_start_lat", start_cyc - addr_cyc, 32'd1);
    chk("rd_addr", last_addr, addr);
    chk("rd_wrap", {16'd0, last_wrap}, {16'd0, len});
    chk("rd_no_rx", rx_n - rx0, 32'd0);
    chk("rd_dummies", cmd_hs_n - hs0, 2 + rd_cycles);
  endtask

  initial begin
    int a0, rx0, e0;
    logic [31:0] w1, d0, d1;
`ifdef SPI_AXI_SEQ_ERRCNT_EN
    logic [7:0] ec0;
`endif
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", plug_addr, 32'd0);
    chk("rst_wrap", {16'd0, plug_wrap_length}, 32'd0);
    chk("rst_addr_valid", {31'd0, plug_addr_valid}, 32'd0);
    chk("rst_start", {31'd0, plug_start_tx}, 32'd0);
    chk("rst_rx_valid", {31'd0, plug_rx_valid}, 32'd0);
    chk("rst_err", {31'd0, err_opcode}, 32'd0);
`ifdef SPI_AXI_SEQ_ERRCNT_EN
    chk("rst_errcnt", {24'd0, err_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    do_write(16'd3, 32'h1C00_0000, 1'b0);
    do_read(16'd2, 32'h1C00_0010);
    do_write(16'd0, 32'h1C00_0020, 1'b0);

    e0 = err_pulses;
    send_word(32'h5500_0004, "bad_hdr");
    chk("bad_busy", {31'd0, busy}, 32'd0);
    do_write(16'd1, 32'h1C00_0030, 1'b0);
    chk("bad_err_pulse", err_pulses - e0, 32'd1);

    // Abort in the data phase.
`ifdef SPI_AXI_SEQ_ERRCNT_EN
    ec0 = err_count;
`endif
    rx0 = rx_n;
    rdy_force = 1'b1;
    send_word(32'h0200_0004, "ab_hdr");
    send_word(32'h1C00_0040, "ab_addr");
    w1 = $urandom;
    send_word(w1, "ab_d0");
    cs = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = $urandom;
    @(negedge clk);
    chk("ab_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("ab_rx_valid", {31'd0, plug_rx_valid}, 32'd0);
    chk("ab_busy_same", {31'd0, busy}, 32'd1);
    tick();
    chk("ab_busy_next", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("ab_idle_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    cs = 1'b0;
    chk("ab_rx_count", rx_n - rx0, 32'd1);
    chk("ab_rx_data", rx_log[10'(rx0)], w1);
`ifdef SPI_AXI_SEQ_ERRCNT_EN
    chk("ab_errcnt", {24'd0, err_count - ec0}, 32'd1);
`endif

    // Abort in LOAD suppresses the address pulse.
    a0 = addr_pulses;
    send_word(32'h0B00_0002, "abl_hdr");
    send_word(32'h1C00_0050, "abl_addr");
    cs = 1'b1;
    @(negedge clk);
    chk("abl_no_pulse", {31'd0, plug_addr_valid}, 32'd0);
    tick();
    cs = 1'b0;
    chk("abl_busy", {31'd0, busy}, 32'd0);
    chk("abl_pulses", addr_pulses - a0, 32'd0);
    chk("abl_addr_held", plug_addr, 32'h1C00_0050);

    // Backpressure on the plug RX port.
    rx0 = rx_n;
    rdy_rand = 1'b0;
    rdy_force = 1'b0;
    send_word(32'h0200_0002, "st_hdr");
    send_word(32'h1C00_0060, "st_addr");
    d0 = $urandom;
    d1 = $urandom;
    cmd_data = d0;
    cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("st_rx_valid", {31'd0, plug_rx_valid}, 32'd1);
      chk("st_rx_data", plug_rx_data, d0);
      tick();
    end
    rdy_force = 1'b1;
    send_word(d0, "st_d0");
    send_word(d1, "st_d1");
    chk("st_busy", {31'd0, busy}, 32'd0);
    chk("st_rx_count", rx_n - rx0, 32'd2);
    chk("st_rx_d0", rx_log[10'(rx0)], d0);
    chk("st_rx_d1", rx_log[10'(rx0 + 1)], d1);

    // Randomized mixed commands.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(16'($urandom_range(0, 5)), $urandom, 1'b1);
      else
        do_read(16'($urandom_range(0, 5)), $urandom);
    end

    // Asynchronous reset mid-command.
    send_word(32'h0200_0003, "rst_hdr");
    send_word(32'h1C00_0070, "rst_addr2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_addr", plug_addr, 32'd0);
    chk("mid_rst_wrap", {16'd0, plug_wrap_length}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_write(16'd2, 32'h1C00_0080, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
